// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU and its arbiter: word/op widths, opcode
// encodings, the undefined-op boundary, FSM state type and opcode helpers.
`ifndef ALU_CONST_DEFINED
`define ALU_CONST_DEFINED
`define WIDTH_WORD   16
`define WIDTH_OP     3
`define OP_ADD       3'b000
`define OP_SUB       3'b001
`define OP_AND       3'b010
`define OP_OR        3'b011
`define OP_NOT       3'b100
`define OP_MV        3'b101
// Opcodes at or above this value have no defined operation.
`define OP_UNDEF_MIN 3'b110
`endif

package alu_arbiter_pkg;

    localparam int WORD_W = `WIDTH_WORD;
    localparam int OP_W   = `WIDTH_OP;

    localparam logic [OP_W-1:0] OP_ADD       = `OP_ADD;
    localparam logic [OP_W-1:0] OP_SUB       = `OP_SUB;
    localparam logic [OP_W-1:0] OP_AND       = `OP_AND;
    localparam logic [OP_W-1:0] OP_OR        = `OP_OR;
    localparam logic [OP_W-1:0] OP_NOT       = `OP_NOT;
    localparam logic [OP_W-1:0] OP_MV        = `OP_MV;
    localparam logic [OP_W-1:0] OP_UNDEF_MIN = `OP_UNDEF_MIN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for encodings that have no operation behind them.
    function automatic logic op_is_undef(input logic [OP_W-1:0] op);
        return (op >= OP_UNDEF_MIN);
    endfunction

    // Only the arithmetic ops produce a meaningful carry/borrow.
    function automatic logic op_has_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU. The carry output is only meaningful for ADD/SUB; for
// other ops it carries whatever the adder produced and must be masked by
// the consumer. When inactive, all outputs are zero.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic            active,
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [W-1:0]    y,
    output logic            carry
);

    logic [W:0] sum_ext;
    logic [W:0] diff_ext;

    // Result select; carry defaults to the raw adder carry for every op.
    always_comb begin
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};
        y        = '0;
        carry    = sum_ext[W];
        if (!active) begin
            carry = 1'b0;
        end else begin
            case (op)
                OP_ADD: y = sum_ext[W-1:0];
                OP_SUB: begin
                    y     = diff_ext[W-1:0];
                    carry = diff_ext[W];
                end
                OP_AND: y = a & b;
                OP_OR:  y = a | b;
                OP_NOT: y = ~a;
                OP_MV:  y = a;
                default: y = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Accept in IDLE, evaluate the ALU in EXEC, hold a registered response in
// RESP until consumed. Undefined opcodes return y=0 with rsp_err set.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [OP_W-1:0] req_op0,
    input  logic [OP_W-1:0] req_op1,
    input  logic [W-1:0]    req_a0,
    input  logic [W-1:0]    req_b0,
    input  logic [W-1:0]    req_a1,
    input  logic [W-1:0]    req_b1,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_y,
    output logic            rsp_carry,
    output logic            rsp_err
);

    state_t          state_reg;
    state_t          state_next;

    logic            last_reg;
    logic            id_reg;
    logic [OP_W-1:0] op_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;

    logic            rsp_id_reg;
    logic [W-1:0]    rsp_y_reg;
    logic            rsp_carry_reg;
    logic            rsp_err_reg;

    logic            grant_valid;
    logic            grant_id;
    logic            accept;
    logic            alu_active;
    logic [W-1:0]    alu_y;
    logic            alu_carry;

    // Grant selection: a lone requester wins; on a tie the one not served last.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_id    = ~last_reg;
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, ready and ALU enable. Ready never looks at rsp_ready.
    always_comb begin
        state_next = state_reg;
        req_ready  = 2'b00;
        accept     = 1'b0;
        alu_active = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    req_ready  = grant_id ? 2'b10 : 2'b01;
                    accept     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_active = ~op_is_undef(op_reg);
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand latch on accept and response capture on the EXEC edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_reg      <= 1'b1;
            id_reg        <= 1'b0;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            rsp_id_reg    <= 1'b0;
            rsp_y_reg     <= '0;
            rsp_carry_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                id_reg <= grant_id;
                op_reg <= grant_id ? req_op1 : req_op0;
                a_reg  <= grant_id ? req_a1  : req_a0;
                b_reg  <= grant_id ? req_b1  : req_b0;
            end
            if (state_reg == ST_EXEC) begin
                rsp_id_reg    <= id_reg;
                rsp_y_reg     <= alu_y;
                rsp_carry_reg <= alu_carry & op_has_carry(op_reg);
                rsp_err_reg   <= op_is_undef(op_reg);
                last_reg      <= id_reg;
            end
        end
    end

    alu #(
        .W(W)
    ) u_alu (
        .active(alu_active),
        .op    (op_reg),
        .a     (a_reg),
        .b     (b_reg),
        .y     (alu_y),
        .carry (alu_carry)
    );

    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_id    = rsp_id_reg;
    assign rsp_y     = rsp_y_reg;
    assign rsp_carry = rsp_carry_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter at W=8: arbitration order, latency,
// carry masking, backpressure, undefined opcodes and reset mid-operation.
module tb_alu_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [2:0]   req_op0;
    logic [2:0]   req_op1;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_b0;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b1;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_y;
    logic         rsp_carry;
    logic         rsp_err;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op0  (req_op0),
        .req_op1  (req_op1),
        .req_a0   (req_a0),
        .req_b0   (req_b0),
        .req_a1   (req_a1),
        .req_b1   (req_b1),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_y    (rsp_y),
        .rsp_carry(rsp_carry),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks a full response and prints one line for the transaction.
    task automatic check_rsp(input string tag, input logic id, input logic [W-1:0] y,
                             input logic c, input logic e);
        $display("txn %s: valid=%0b id=%0d y=%h carry=%0b err=%0b",
                 tag, rsp_valid, rsp_id, rsp_y, rsp_carry, rsp_err);
        check({tag, ".valid"}, 16'(rsp_valid), 16'(1'b1));
        check({tag, ".id"},    16'(rsp_id),    16'(id));
        check({tag, ".y"},     16'(rsp_y),     16'(y));
        check({tag, ".carry"}, 16'(rsp_carry), 16'(c));
        check({tag, ".err"},   16'(rsp_err),   16'(e));
    endtask

    // Consume the current response with a one-cycle rsp_ready pulse.
    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op0   = 3'b000;
        req_op1   = 3'b000;
        req_a0    = '0;
        req_b0    = '0;
        req_a1    = '0;
        req_b1    = '0;
        rsp_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst.valid", 16'(rsp_valid), 16'h0);
        check("rst.id",    16'(rsp_id),    16'h0);
        check("rst.y",     16'(rsp_y),     16'h0);
        check("rst.carry", 16'(rsp_carry), 16'h0);
        check("rst.err",   16'(rsp_err),   16'h0);
        check("rst.ready", 16'(req_ready), 16'h0);
        rst_n = 1'b1;
        tick();

        // Single request: ADD 0xF0+0x20
        req_valid = 2'b01; req_op0 = 3'b000; req_a0 = 8'hF0; req_b0 = 8'h20;
        #1;
        check("add.ready", 16'(req_ready), 16'h1);
        tick();
        req_valid = 2'b00;
        check("add.exec_ready", 16'(req_ready), 16'h0);
        check("add.exec_valid", 16'(rsp_valid), 16'h0);
        tick();
        check_rsp("add", 1'b0, 8'h10, 1'b1, 1'b0);
        consume();
        check("add.done_valid", 16'(rsp_valid), 16'h0);

        // Fresh reset so that requester 0 wins the first tie
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_valid = 2'b11;
        req_op0 = 3'b001; req_a0 = 8'h05; req_b0 = 8'h07;
        req_op1 = 3'b101; req_a1 = 8'h3C; req_b1 = 8'h3C;
        #1;
        check("tie1.ready", 16'(req_ready), 16'h1);
        tick();
        req_valid = 2'b10;
        tick();
        check_rsp("sub", 1'b0, 8'hFE, 1'b1, 1'b0);
        // req1 is still waiting: no ready while the response is pending
        check("sub.resp_ready", 16'(req_ready), 16'h0);
        consume();
        // Requester 0 returns with ADD 0xFF+0x01; tie goes to requester 1
        req_valid = 2'b11;
        req_op0 = 3'b000; req_a0 = 8'hFF; req_b0 = 8'h01;
        #1;
        check("tie2.ready", 16'(req_ready), 16'h2);
        tick();
        req_valid = 2'b01;
        tick();
        check_rsp("mv", 1'b1, 8'h3C, 1'b0, 1'b0);
        // Third tie: requester 1 presents AND 0xFF&0x0F, requester 0 wins
        req_valid = 2'b11;
        req_op1 = 3'b010; req_a1 = 8'hFF; req_b1 = 8'h0F;
        consume();
        check("tie3.ready", 16'(req_ready), 16'h1);
        tick();
        req_valid = 2'b10;
        tick();
        check_rsp("add_ff", 1'b0, 8'h00, 1'b1, 1'b0);
        consume();
        check("and.ready", 16'(req_ready), 16'h2);
        tick();
        req_valid = 2'b00;
        tick();
        check_rsp("and", 1'b1, 8'h0F, 1'b0, 1'b0);

        // Backpressure: OR request waits while the AND response is held
        req_valid = 2'b10;
        req_op1 = 3'b011; req_a1 = 8'h0F; req_b1 = 8'hF0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp.valid", 16'(rsp_valid), 16'h1);
            check("bp.y",     16'(rsp_y),     16'h0F);
            check("bp.ready", 16'(req_ready), 16'h0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.ready_on_rsp", 16'(req_ready), 16'h0);
        tick();
        rsp_ready = 1'b0;
        check("bp.accept_ready", 16'(req_ready), 16'h2);
        tick();
        req_valid = 2'b00;
        check("bp.exec_valid", 16'(rsp_valid), 16'h0);
        tick();
        check_rsp("or", 1'b1, 8'hFF, 1'b0, 1'b0);
        consume();

        // Undefined opcode from requester 1
        req_valid = 2'b10;
        req_op1 = 3'b111; req_a1 = 8'h55; req_b1 = 8'hAA;
        #1;
        check("undef.ready", 16'(req_ready), 16'h2);
        tick();
        req_valid = 2'b00;
        tick();
        check_rsp("undef", 1'b1, 8'h00, 1'b0, 1'b1);
        consume();
        // NOT 0xA5 clears the error flag
        req_valid = 2'b01;
        req_op0 = 3'b100; req_a0 = 8'hA5; req_b0 = 8'hA5;
        tick();
        req_valid = 2'b00;
        tick();
        check_rsp("not", 1'b0, 8'h5A, 1'b0, 1'b0);
        consume();

        // Reset during EXEC: the op is discarded (last is 0 before reset)
        req_valid = 2'b01;
        req_op0 = 3'b000; req_a0 = 8'h01; req_b0 = 8'h01;
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("rstmid.no_rsp", 16'(rsp_valid), 16'h0);
            tick();
        end
        req_valid = 2'b11;
        req_op0 = 3'b001; req_a0 = 8'h10; req_b0 = 8'h01;
        req_op1 = 3'b101; req_a1 = 8'h77; req_b1 = 8'h77;
        #1;
        check("rstmid.tie_ready", 16'(req_ready), 16'h1);
        tick();
        req_valid = 2'b10;
        tick();
        check_rsp("post_rst", 1'b0, 8'h0F, 1'b0, 1'b0);
        consume();
        req_valid = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
